// File: rtl/rggen_wishbone_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rggen_wishbone_arbiter_if
//  Brief    : Bus bundle for the Wishbone arbiter. Per-master lanes are packed
//             with master 0 in the LSBs; the single slave port is unpacked.
//  Revision : 1.0 - initial release
// ============================================================================
interface rggen_wishbone_arbiter_if #(
    parameter int NUM_MASTERS   = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    localparam int c_sel_w = BUS_WIDTH / 8;

    // Master lanes
    logic [NUM_MASTERS-1:0]               i_m_cyc;
    logic [NUM_MASTERS-1:0]               i_m_stb;
    logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] i_m_adr;
    logic [NUM_MASTERS-1:0]               i_m_we;
    logic [NUM_MASTERS*BUS_WIDTH-1:0]     i_m_dat;
    logic [NUM_MASTERS*c_sel_w-1:0]       i_m_sel;
    logic [NUM_MASTERS-1:0]               o_m_stall;
    logic [NUM_MASTERS-1:0]               o_m_ack;
    logic [NUM_MASTERS-1:0]               o_m_err;
    logic [NUM_MASTERS-1:0]               o_m_rty;
    logic [NUM_MASTERS*BUS_WIDTH-1:0]     o_m_dat;

    // Shared slave port
    logic                                 o_s_cyc;
    logic                                 o_s_stb;
    logic                                 i_s_stall;
    logic [ADDRESS_WIDTH-1:0]             o_s_adr;
    logic                                 o_s_we;
    logic [BUS_WIDTH-1:0]                 o_s_dat;
    logic [c_sel_w-1:0]                   o_s_sel;
    logic                                 i_s_ack;
    logic                                 i_s_err;
    logic                                 i_s_rty;
    logic [BUS_WIDTH-1:0]                 i_s_dat;

    // Current owner, one-hot
    logic [NUM_MASTERS-1:0]               o_grant;

    // Arbiter view: it is the slave of the masters and drives the slave port
    modport slave (
        input  i_m_cyc, i_m_stb, i_m_adr, i_m_we, i_m_dat, i_m_sel,
        output o_m_stall, o_m_ack, o_m_err, o_m_rty, o_m_dat,
        output o_s_cyc, o_s_stb, o_s_adr, o_s_we, o_s_dat, o_s_sel,
        input  i_s_stall, i_s_ack, i_s_err, i_s_rty, i_s_dat,
        output o_grant
    );

    // Environment view: masters and the shared slave around the arbiter
    modport master (
        output i_m_cyc, i_m_stb, i_m_adr, i_m_we, i_m_dat, i_m_sel,
        input  o_m_stall, o_m_ack, o_m_err, o_m_rty, o_m_dat,
        input  o_s_cyc, o_s_stb, o_s_adr, o_s_we, o_s_dat, o_s_sel,
        output i_s_stall, i_s_ack, i_s_err, i_s_rty, i_s_dat,
        input  o_grant
    );
endinterface
`default_nettype wire

// File: rtl/rggen_wishbone_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rggen_wishbone_arbiter
//  Brief    : Round-robin, CYC-granular arbiter sharing one pipelined Wishbone
//             slave between NUM_MASTERS masters, with outstanding-request
//             tracking and an optional response watchdog that aborts with ERR.
//  Revision : 1.0 - initial release
// ============================================================================
module rggen_wishbone_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int MAX_PENDING    = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst,
    rggen_wishbone_arbiter_if.slave    bus
);
    localparam int c_idx_w  = $clog2(NUM_MASTERS);
    localparam int c_cnt_w  = c_idx_w + 1;
    localparam int c_sel_w  = BUS_WIDTH / 8;
    localparam int c_pend_w = $clog2(MAX_PENDING + 1);
    localparam int c_wd_w   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [c_pend_w-1:0]    c_pend_one  = c_pend_w'(1);
    localparam logic [c_pend_w-1:0]    c_pend_max  = c_pend_w'(MAX_PENDING);
    localparam logic [c_wd_w-1:0]      c_wd_one    = c_wd_w'(1);
    localparam logic [c_wd_w-1:0]      c_wd_limit  = c_wd_w'(TIMEOUT_CYCLES);
    localparam logic [NUM_MASTERS-1:0] c_grant_lsb = NUM_MASTERS'(1);
    localparam logic [c_cnt_w-1:0]     c_num_m     = c_cnt_w'(NUM_MASTERS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t                 r_state,    w_state_next;
    logic [NUM_MASTERS-1:0] r_grant,    w_grant_next;
    logic [c_idx_w-1:0]     r_owner,    w_owner_next;
    logic [c_idx_w-1:0]     r_pointer,  w_pointer_next;
    logic [c_pend_w-1:0]    r_pending,  w_pending_next;
    logic [c_wd_w-1:0]      r_watchdog, w_watchdog_next;

    logic                   w_found;
    logic [c_idx_w-1:0]     w_winner;
    logic [c_cnt_w-1:0]     w_cand;

    logic                   w_owner_cyc;
    logic                   w_owner_stb;
    logic                   w_pending_nz;
    logic                   w_accept;
    logic                   w_resp;
    logic                   w_s_cyc;
    logic                   w_s_stb;
    logic                   w_owner_stall;
    logic                   w_owner_ack;
    logic                   w_owner_err;
    logic                   w_owner_rty;
    logic [NUM_MASTERS-1:0] w_m_stall;
    logic [NUM_MASTERS-1:0] w_m_ack;
    logic [NUM_MASTERS-1:0] w_m_err;
    logic [NUM_MASTERS-1:0] w_m_rty;

    assign w_owner_cyc  = bus.i_m_cyc[r_owner];
    assign w_owner_stb  = bus.i_m_stb[r_owner];
    assign w_pending_nz = (r_pending != '0);

    // Round-robin search: first CYC-requester after the pointer, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = {1'b0, r_pointer} + c_cnt_w'(i);
            if (w_cand >= c_num_m) begin
                w_cand = w_cand - c_num_m;
            end
            if (!w_found && bus.i_m_cyc[w_cand[c_idx_w-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[c_idx_w-1:0];
            end
        end
    end

    // Next-state and owner-side handshake decode
    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_owner_next    = r_owner;
        w_pointer_next  = r_pointer;
        w_pending_next  = r_pending;
        w_watchdog_next = r_watchdog;
        w_s_cyc         = 1'b0;
        w_s_stb         = 1'b0;
        w_owner_stall   = 1'b1;
        w_owner_ack     = 1'b0;
        w_owner_err     = 1'b0;
        w_owner_rty     = 1'b0;
        w_accept        = 1'b0;
        w_resp          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next    = ST_OWNED;
                    w_grant_next    = c_grant_lsb << w_winner;
                    w_owner_next    = w_winner;
                    w_pending_next  = '0;
                    w_watchdog_next = '0;
                end
            end

            ST_OWNED: begin
                // Dropping CYC aborts the cycle on the slave side at once
                w_s_cyc       = w_owner_cyc;
                w_s_stb       = w_owner_cyc & w_owner_stb & (r_pending < c_pend_max);
                w_owner_stall = bus.i_s_stall | (r_pending == c_pend_max);
                w_owner_ack   = bus.i_s_ack & w_pending_nz;
                w_owner_err   = bus.i_s_err & w_pending_nz;
                w_owner_rty   = bus.i_s_rty & w_pending_nz;
                w_resp        = w_owner_ack | w_owner_err | w_owner_rty;
                w_accept      = w_s_stb & ~bus.i_s_stall;

                if (!w_owner_cyc) begin
                    // Release: owner becomes lowest priority for the next round
                    w_state_next    = ST_IDLE;
                    w_grant_next    = '0;
                    w_pointer_next  = r_owner;
                    w_pending_next  = '0;
                    w_watchdog_next = '0;
                end else begin
                    if (w_accept && !w_resp) begin
                        w_pending_next = r_pending + c_pend_one;
                    end else if (!w_accept && w_resp) begin
                        w_pending_next = r_pending - c_pend_one;
                    end

                    if (TIMEOUT_CYCLES > 0) begin
                        if (w_accept || w_resp || !w_pending_nz) begin
                            w_watchdog_next = '0;
                        end else if ((r_watchdog + c_wd_one) == c_wd_limit) begin
                            w_watchdog_next = '0;
                            w_state_next    = ST_ABORT;
                        end else begin
                            w_watchdog_next = r_watchdog + c_wd_one;
                        end
                    end
                end
            end

            ST_ABORT: begin
                // Slave port is closed; drain outstanding requests as ERRs
                if (!w_owner_cyc) begin
                    w_state_next    = ST_IDLE;
                    w_grant_next    = '0;
                    w_pointer_next  = r_owner;
                    w_pending_next  = '0;
                    w_watchdog_next = '0;
                end else if (w_pending_nz) begin
                    w_owner_err    = 1'b1;
                    w_pending_next = r_pending - c_pend_one;
                    if (r_pending == c_pend_one) begin
                        w_state_next = ST_OWNED;
                    end
                end else begin
                    w_state_next = ST_OWNED;
                end
            end

            default: begin
                w_state_next    = ST_IDLE;
                w_grant_next    = '0;
                w_pending_next  = '0;
                w_watchdog_next = '0;
            end
        endcase
    end

    // Route owner handshake to its lane; everyone else stalls and sees no response
    always_comb begin
        w_m_stall          = '1;
        w_m_ack            = '0;
        w_m_err            = '0;
        w_m_rty            = '0;
        w_m_stall[r_owner] = w_owner_stall;
        w_m_ack[r_owner]   = w_owner_ack;
        w_m_err[r_owner]   = w_owner_err;
        w_m_rty[r_owner]   = w_owner_rty;
    end

    // Arbiter state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_pointer  <= c_idx_w'(NUM_MASTERS - 1);
            r_pending  <= '0;
            r_watchdog <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_owner    <= w_owner_next;
            r_pointer  <= w_pointer_next;
            r_pending  <= w_pending_next;
            r_watchdog <= w_watchdog_next;
        end
    end

    assign bus.o_s_cyc   = w_s_cyc;
    assign bus.o_s_stb   = w_s_stb;
    assign bus.o_s_adr   = bus.i_m_adr[int'(r_owner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign bus.o_s_we    = bus.i_m_we[r_owner];
    assign bus.o_s_dat   = bus.i_m_dat[int'(r_owner)*BUS_WIDTH +: BUS_WIDTH];
    assign bus.o_s_sel   = bus.i_m_sel[int'(r_owner)*c_sel_w +: c_sel_w];
    assign bus.o_m_stall = w_m_stall;
    assign bus.o_m_ack   = w_m_ack;
    assign bus.o_m_err   = w_m_err;
    assign bus.o_m_rty   = w_m_rty;
    assign bus.o_m_dat   = {NUM_MASTERS{bus.i_s_dat}};
    assign bus.o_grant   = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_rggen_wishbone_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rggen_wishbone_arbiter
//  Brief    : Directed self-checking bench for rggen_wishbone_arbiter.
//             dut_a: MAX_PENDING=1, no watchdog. dut_b: MAX_PENDING=2, 8-cycle
//             watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rggen_wishbone_arbiter;
    localparam int NM = 2;
    localparam int AW = 8;
    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rggen_wishbone_arbiter_if #(.NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_a ();
    rggen_wishbone_arbiter_if #(.NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_b ();

    rggen_wishbone_arbiter #(
        .NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW),
        .MAX_PENDING(1), .TIMEOUT_CYCLES(0)
    ) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));

    rggen_wishbone_arbiter #(
        .NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW),
        .MAX_PENDING(2), .TIMEOUT_CYCLES(8)
    ) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

    // Advance to 2 time units after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus_a.i_m_cyc = '0; bus_a.i_m_stb = '0; bus_a.i_m_adr = '0; bus_a.i_m_we = '0;
        bus_a.i_m_dat = '0; bus_a.i_m_sel = '0; bus_a.i_s_stall = 1'b0; bus_a.i_s_ack = 1'b0;
        bus_a.i_s_err = 1'b0; bus_a.i_s_rty = 1'b0; bus_a.i_s_dat = '0;
        bus_b.i_m_cyc = '0; bus_b.i_m_stb = '0; bus_b.i_m_adr = '0; bus_b.i_m_we = '0;
        bus_b.i_m_dat = '0; bus_b.i_m_sel = '0; bus_b.i_s_stall = 1'b0; bus_b.i_s_ack = 1'b0;
        bus_b.i_s_err = 1'b0; bus_b.i_s_rty = 1'b0; bus_b.i_s_dat = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        #1;
        checks++;
        if ({bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_s_stb} !== 4'b00_0_0) begin
            errors++;
            $display("FAIL reset_grant_cyc: got %b expected %b", {bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_s_stb}, 4'b0000);
        end
        checks++;
        if ({bus_a.o_m_stall, bus_a.o_m_ack, bus_a.o_m_err, bus_a.o_m_rty} !== 8'b11_00_00_00) begin
            errors++;
            $display("FAIL reset_master_resp: got %b expected %b", {bus_a.o_m_stall, bus_a.o_m_ack, bus_a.o_m_err, bus_a.o_m_rty}, 8'b11000000);
        end
        checks++;
        if ({bus_b.o_grant, bus_b.o_s_cyc, bus_b.o_m_stall, bus_b.o_m_err} !== 7'b00_0_11_00) begin
            errors++;
            $display("FAIL reset_dut_b: got %b expected %b", {bus_b.o_grant, bus_b.o_s_cyc, bus_b.o_m_stall, bus_b.o_m_err}, 7'b0001100);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        bus_a.i_m_cyc[0] = 1'b1; bus_a.i_m_stb[0] = 1'b1; bus_a.i_m_we[0] = 1'b0;
        bus_a.i_m_adr[7:0] = 8'h10; bus_a.i_m_sel[3:0] = 4'hF;
        #1;
        checks++;
        if ({bus_a.o_grant, bus_a.o_m_stall} !== 4'b00_11) begin
            errors++;
            $display("FAIL read_idle_stall: got %b expected %b", {bus_a.o_grant, bus_a.o_m_stall}, 4'b0011);
        end
        step(); #1;
        checks++;
        if ({bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_s_stb, bus_a.o_s_we, bus_a.o_s_adr} !== {2'b01, 1'b1, 1'b1, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL read_grant_req: got %b expected %b", {bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_s_stb, bus_a.o_s_we, bus_a.o_s_adr}, {2'b01, 1'b1, 1'b1, 1'b0, 8'h10});
        end
        checks++;
        if (bus_a.o_m_stall !== 2'b10) begin
            errors++;
            $display("FAIL read_owner_stall: got %b expected %b", bus_a.o_m_stall, 2'b10);
        end
        step();
        bus_a.i_m_stb[0] = 1'b0;
        #1;
        checks++;
        if ({bus_a.o_m_stall[0], bus_a.o_s_stb} !== 2'b1_0) begin
            errors++;
            $display("FAIL read_pending_stall: got %b expected %b", {bus_a.o_m_stall[0], bus_a.o_s_stb}, 2'b10);
        end
        step();
        bus_a.i_s_ack = 1'b1; bus_a.i_s_dat = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus_a.o_m_ack !== 2'b01) begin
            errors++;
            $display("FAIL read_ack: got %b expected %b", bus_a.o_m_ack, 2'b01);
        end
        checks++;
        if (bus_a.o_m_dat[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_data: got %h expected %h", bus_a.o_m_dat[31:0], 32'hDEAD_BEEF);
        end
        step();
        bus_a.i_s_ack = 1'b0;
        #1;
        checks++;
        if ({bus_a.o_m_ack, bus_a.o_m_stall[0]} !== 3'b00_0) begin
            errors++;
            $display("FAIL read_after_ack: got %b expected %b", {bus_a.o_m_ack, bus_a.o_m_stall[0]}, 3'b000);
        end
        bus_a.i_m_cyc[0] = 1'b0;
        #1;
        checks++;
        if (bus_a.o_s_cyc !== 1'b0) begin
            errors++;
            $display("FAIL read_release_cyc: got %b expected %b", bus_a.o_s_cyc, 1'b0);
        end
        step(); #1;
        checks++;
        if (bus_a.o_grant !== 2'b00) begin
            errors++;
            $display("FAIL read_grant_clear: got %b expected %b", bus_a.o_grant, 2'b00);
        end
    endtask

    task automatic test_alternate();
        int exp_order [4] = '{0, 1, 0, 1};
        int gm;
        int gap;
        logic [31:0] wdat;
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        bus_a.i_m_cyc = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            gm   = exp_order[k];
            wdat = 32'hA5A5_0000 | k;
            checks++;
            if (bus_a.o_grant !== (2'b01 << gm)) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got %b expected %b", k, bus_a.o_grant, 2'b01 << gm);
            end
            bus_a.i_m_stb[gm] = 1'b1; bus_a.i_m_we[gm] = 1'b1;
            bus_a.i_m_adr[gm*AW +: AW] = 8'h40 + 8'(k);
            bus_a.i_m_dat[gm*BW +: BW] = wdat;
            bus_a.i_m_sel[gm*4 +: 4] = 4'hF;
            #1;
            checks++;
            if ({bus_a.o_s_stb, bus_a.o_s_we, bus_a.o_s_dat} !== {1'b1, 1'b1, wdat}) begin
                errors++;
                $display("FAIL alt_write[%0d]: got %h expected %h", k, {bus_a.o_s_stb, bus_a.o_s_we, bus_a.o_s_dat}, {1'b1, 1'b1, wdat});
            end
            step();
            bus_a.i_m_stb[gm] = 1'b0;
            bus_a.i_s_ack = 1'b1;
            #1;
            checks++;
            if (bus_a.o_m_ack !== (2'b01 << gm)) begin
                errors++;
                $display("FAIL alt_ack[%0d]: got %b expected %b", k, bus_a.o_m_ack, 2'b01 << gm);
            end
            step();
            bus_a.i_s_ack = 1'b0;
            bus_a.i_m_cyc[gm] = 1'b0;
            #1;
            checks++;
            if (bus_a.o_s_cyc !== 1'b0) begin
                errors++;
                $display("FAIL alt_release[%0d]: got %b expected %b", k, bus_a.o_s_cyc, 1'b0);
            end
            if (k < 3) begin
                gap = 0;
                do begin
                    step();
                    gap++;
                    if (gap == 1) bus_a.i_m_cyc[gm] = 1'b1;
                end while (bus_a.o_grant == 2'b00 && gap < 10);
                checks++;
                if (gap !== 2) begin
                    errors++;
                    $display("FAIL alt_gap[%0d]: got %0d cycles expected %0d", k, gap, 2);
                end
            end
        end
        bus_a.i_m_cyc = 2'b00;
        step();
        step();
    endtask

    task automatic test_stream();
        logic [31:0] wdat [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        logic [3:0]  wsel [3] = '{4'h1, 4'h3, 4'hF};
        int  w = 0, acc = 0, acks = 0, tb_pend = 0, budget = 0;
        logic ack_next = 1'b0;
        logic ack_drv;
        logic exp_stb;
        bus_a.i_m_cyc[0] = 1'b1; bus_a.i_m_we[0] = 1'b1; bus_a.i_m_adr[7:0] = 8'h08;
        step();
        while (acks < 3 && budget < 30) begin
            ack_drv = ack_next;
            ack_next = 1'b0;
            bus_a.i_s_ack = ack_drv;
            bus_a.i_m_stb[0] = (w < 3);
            if (w < 3) begin
                bus_a.i_m_dat[31:0] = wdat[w];
                bus_a.i_m_sel[3:0]  = wsel[w];
            end
            #1;
            exp_stb = (w < 3) && (tb_pend == 0);
            checks++;
            if ({bus_a.o_s_stb, bus_a.o_m_stall[0]} !== {exp_stb, (tb_pend == 1)}) begin
                errors++;
                $display("FAIL stream_stb_stall[%0d]: got %b expected %b", budget, {bus_a.o_s_stb, bus_a.o_m_stall[0]}, {exp_stb, (tb_pend == 1)});
            end
            checks++;
            if (bus_a.o_m_ack !== {1'b0, ack_drv && (tb_pend > 0)}) begin
                errors++;
                $display("FAIL stream_ack[%0d]: got %b expected %b", budget, bus_a.o_m_ack, {1'b0, ack_drv && (tb_pend > 0)});
            end
            if (bus_a.o_m_ack[0]) acks++;
            if (bus_a.o_s_stb && !bus_a.i_s_stall) begin
                checks++;
                if ({bus_a.o_s_dat, bus_a.o_s_sel} !== {wdat[acc % 3], wsel[acc % 3]}) begin
                    errors++;
                    $display("FAIL stream_data[%0d]: got %h expected %h", acc, {bus_a.o_s_dat, bus_a.o_s_sel}, {wdat[acc % 3], wsel[acc % 3]});
                end
                acc++;
                w++;
                ack_next = 1'b1;
                tb_pend++;
            end
            if (ack_drv && tb_pend > 0) tb_pend--;
            step();
            budget++;
        end
        bus_a.i_s_ack = 1'b0;
        bus_a.i_m_stb[0] = 1'b0;
        checks++;
        if ({acc, acks} !== {32'd3, 32'd3}) begin
            errors++;
            $display("FAIL stream_counts: got accepts=%0d acks=%0d expected 3 and 3", acc, acks);
        end
        bus_a.i_m_cyc[0] = 1'b0;
        step();
        step();
    endtask

    task automatic test_err();
        bus_a.i_m_cyc[0] = 1'b1; bus_a.i_m_stb[0] = 1'b1; bus_a.i_m_we[0] = 1'b0;
        bus_a.i_m_adr[7:0] = 8'hFC;
        step(); #1;
        checks++;
        if ({bus_a.o_s_cyc, bus_a.o_s_stb, bus_a.o_s_adr} !== {1'b1, 1'b1, 8'hFC}) begin
            errors++;
            $display("FAIL err_request: got %h expected %h", {bus_a.o_s_cyc, bus_a.o_s_stb, bus_a.o_s_adr}, {1'b1, 1'b1, 8'hFC});
        end
        step();
        bus_a.i_m_stb[0] = 1'b0;
        bus_a.i_s_err = 1'b1;
        #1;
        checks++;
        if ({bus_a.o_m_err, bus_a.o_m_ack} !== 4'b01_00) begin
            errors++;
            $display("FAIL err_pulse: got %b expected %b", {bus_a.o_m_err, bus_a.o_m_ack}, 4'b0100);
        end
        step();
        bus_a.i_s_err = 1'b0;
        #1;
        checks++;
        if ({bus_a.o_m_err, bus_a.o_m_stall[0]} !== 3'b00_0) begin
            errors++;
            $display("FAIL err_after: got %b expected %b", {bus_a.o_m_err, bus_a.o_m_stall[0]}, 3'b000);
        end
        bus_a.i_m_cyc[0] = 1'b0;
        step();
        step();
    endtask

    task automatic test_watchdog();
        bus_b.i_m_cyc[0] = 1'b1; bus_b.i_m_stb[0] = 1'b1; bus_b.i_m_we[0] = 1'b1;
        bus_b.i_m_adr[7:0] = 8'h24; bus_b.i_m_dat[31:0] = 32'h0BAD_F00D;
        step(); #1;
        checks++;
        if ({bus_b.o_grant, bus_b.o_s_stb} !== 3'b01_1) begin
            errors++;
            $display("FAIL wd_first_accept: got %b expected %b", {bus_b.o_grant, bus_b.o_s_stb}, 3'b011);
        end
        step(); #1;
        checks++;
        if (bus_b.o_s_stb !== 1'b1) begin
            errors++;
            $display("FAIL wd_second_accept: got %b expected %b", bus_b.o_s_stb, 1'b1);
        end
        step();
        bus_b.i_m_stb[0] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++;
            if ({bus_b.o_s_cyc, bus_b.o_m_err, bus_b.o_m_stall[0]} !== 4'b1_00_1) begin
                errors++;
                $display("FAIL wd_wait[%0d]: got %b expected %b", i, {bus_b.o_s_cyc, bus_b.o_m_err, bus_b.o_m_stall[0]}, 4'b1001);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({bus_b.o_s_cyc, bus_b.o_s_stb, bus_b.o_m_err, bus_b.o_m_stall[0]} !== 5'b0_0_01_1) begin
                errors++;
                $display("FAIL wd_abort_err[%0d]: got %b expected %b", i, {bus_b.o_s_cyc, bus_b.o_s_stb, bus_b.o_m_err, bus_b.o_m_stall[0]}, 5'b00011);
            end
            step();
        end
        #1;
        checks++;
        if ({bus_b.o_s_cyc, bus_b.o_m_err, bus_b.o_m_stall[0]} !== 4'b1_00_0) begin
            errors++;
            $display("FAIL wd_back_owned: got %b expected %b", {bus_b.o_s_cyc, bus_b.o_m_err, bus_b.o_m_stall[0]}, 4'b1000);
        end
        bus_b.i_m_cyc[0] = 1'b0;
        step();
        step();
    endtask

    task automatic test_late_ack_reset();
        bus_a.i_m_cyc[0] = 1'b1; bus_a.i_m_stb[0] = 1'b1; bus_a.i_m_we[0] = 1'b0;
        bus_a.i_m_adr[7:0] = 8'h20;
        step(); #1;
        checks++;
        if (bus_a.o_grant !== 2'b01) begin
            errors++;
            $display("FAIL late_grant0: got %b expected %b", bus_a.o_grant, 2'b01);
        end
        step();
        bus_a.i_m_stb[0] = 1'b0; bus_a.i_m_cyc[0] = 1'b0; bus_a.i_m_cyc[1] = 1'b1;
        #1;
        checks++;
        if ({bus_a.o_s_cyc, bus_a.o_m_ack} !== 3'b0_00) begin
            errors++;
            $display("FAIL late_release: got %b expected %b", {bus_a.o_s_cyc, bus_a.o_m_ack}, 3'b000);
        end
        step();
        bus_a.i_s_ack = 1'b1;
        #1;
        checks++;
        if ({bus_a.o_grant, bus_a.o_m_ack} !== 4'b00_00) begin
            errors++;
            $display("FAIL late_ack_dropped: got %b expected %b", {bus_a.o_grant, bus_a.o_m_ack}, 4'b0000);
        end
        step();
        bus_a.i_s_ack = 1'b0;
        #1;
        checks++;
        if ({bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_m_ack} !== 5'b10_1_00) begin
            errors++;
            $display("FAIL late_grant1: got %b expected %b", {bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_m_ack}, 5'b10100);
        end
        bus_a.i_m_stb[1] = 1'b1; bus_a.i_m_adr[15:8] = 8'h44;
        #1;
        checks++;
        if ({bus_a.o_s_stb, bus_a.o_s_adr, bus_a.o_m_stall} !== {1'b1, 8'h44, 2'b01}) begin
            errors++;
            $display("FAIL late_m1_req: got %h expected %h", {bus_a.o_s_stb, bus_a.o_s_adr, bus_a.o_m_stall}, {1'b1, 8'h44, 2'b01});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_s_stb, bus_a.o_m_stall, bus_a.o_m_ack, bus_a.o_m_err, bus_a.o_m_rty}
            !== 12'b00_0_0_11_00_00_00) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", {bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_s_stb, bus_a.o_m_stall, bus_a.o_m_ack, bus_a.o_m_err, bus_a.o_m_rty}, 12'b000011000000);
        end
        step(); #1;
        checks++;
        if ({bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_m_stall} !== 5'b00_0_11) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", {bus_a.o_grant, bus_a.o_s_cyc, bus_a.o_m_stall}, 5'b00011);
        end
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_alternate();
        test_stream();
        test_err();
        test_watchdog();
        test_late_ack_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/rggen_wishbone_arbiter.md
Name: rggen_wishbone_arbiter

Overview:
- Shares one pipelined Wishbone slave port between NUM_MASTERS Wishbone masters, e.g. CPU, USB bridge and DMA feeding the rggen register-block adapter.
- Round-robin, cycle-granular arbitration: the grant is held for the owner's whole CYC.
- Tracks outstanding requests, routes responses back to the owner only, and provides an optional response watchdog that terminates hung transfers with ERR.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDRESS_WIDTH, 8, Wishbone address width.
- BUS_WIDTH, 32, data width; SEL width is BUS_WIDTH/8.
- MAX_PENDING, 1, maximum accepted-but-unanswered requests (1..15).
- TIMEOUT_CYCLES, 0, cycles with pending>0 and no response before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_m_cyc  in  NUM_MASTERS  per-master CYC.
- i_m_stb  in  NUM_MASTERS  per-master STB.
- i_m_adr  in  NUM_MASTERS*ADDRESS_WIDTH  packed addresses, master 0 in the LSBs.
- i_m_we  in  NUM_MASTERS  per-master WE.
- i_m_dat  in  NUM_MASTERS*BUS_WIDTH  packed write data.
- i_m_sel  in  NUM_MASTERS*BUS_WIDTH/8  packed byte selects.
- o_m_stall  out  NUM_MASTERS  per-master STALL.
- o_m_ack  out  NUM_MASTERS  per-master ACK.
- o_m_err  out  NUM_MASTERS  per-master ERR.
- o_m_rty  out  NUM_MASTERS  per-master RTY.
- o_m_dat  out  NUM_MASTERS*BUS_WIDTH  read data; the slave data is broadcast to every lane.
- o_s_cyc  out  1  slave CYC.
- o_s_stb  out  1  slave STB.
- i_s_stall  in  1  slave STALL.
- o_s_adr  out  ADDRESS_WIDTH  slave address.
- o_s_we  out  1  slave WE.
- o_s_dat  out  BUS_WIDTH  slave write data.
- o_s_sel  out  BUS_WIDTH/8  slave byte selects.
- i_s_ack  in  1  slave ACK.
- i_s_err  in  1  slave ERR.
- i_s_rty  in  1  slave RTY.
- i_s_dat  in  BUS_WIDTH  slave read data.
- o_grant  out  NUM_MASTERS  one-hot current owner; all zeros when idle.

Behaviour:
- Reset values:
  - State IDLE; o_grant=0; pending=0; watchdog=0.
  - Round-robin pointer = NUM_MASTERS-1, so master 0 has first priority.
  - o_s_cyc=0, o_s_stb=0; o_m_stall all 1; o_m_ack/err/rty all 0.
- State IDLE:
  - Candidates are masters with i_m_cyc=1.
  - The winner is the first candidate searching pointer+1, pointer+2, ..., wrapping modulo NUM_MASTERS.
  - o_grant is registered: it is set on the next clock and the state moves to OWNED. Arbitration latency is 1 cycle.
  - All masters see stall=1 while in IDLE.
- State OWNED:
  - o_s_cyc = owner CYC. o_s_adr/we/dat/sel are combinational muxes from the owner.
  - o_s_stb = owner STB & (pending<MAX_PENDING).
  - Owner stall = i_s_stall | (pending==MAX_PENDING). Non-owners see stall=1.
  - A request is accepted when o_s_stb & ~i_s_stall; accept increments pending.
  - A response is any of i_s_ack/err/rty while pending>0; a response decrements pending.
  - Accept and response in the same cycle leave pending unchanged.
  - Responses arriving with pending=0 are dropped and do not underflow pending.
  - Owner ACK/ERR/RTY = slave strobes gated by pending>0, combinational with zero added latency. Non-owners receive 0.
- Owner release:
  - When owner CYC falls, o_s_cyc falls in the same cycle (Wishbone abort).
  - pending and watchdog clear, pointer = owner index, o_grant clears on the next clock, and the state returns to IDLE.
  - A new grant is therefore possible 2 cycles after release. A re-requesting owner ranks last.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts cycles in OWNED with pending>0 and no response; it resets on any response or accept.
  - When the count reaches TIMEOUT_CYCLES the state moves to ABORT.
- State ABORT:
  - o_s_cyc=0 and o_s_stb=0.
  - One owner ERR pulse per cycle while pending>0, decrementing pending each cycle.
  - Owner stall=1 and slave responses are ignored.
  - When pending reaches 0: OWNED if owner CYC is still 1, else IDLE with the release rules above.
  - If owner CYC drops during ABORT, the remaining ERRs are suppressed and the release rules apply.
- Reset asserted mid-operation forces all reset values immediately (asynchronous); in-flight transfers are lost.
- A master holding CYC indefinitely starves the others; this is accepted by design, and masters must drop CYC between bursts.

Test Plan:
- Reset, master 0 single read of adr 0x10; slave acks after 2 cycles with data 0xDEADBEEF -> o_grant=01 one cycle after CYC; m0 ACK with o_m_dat=0xDEADBEEF; m1 ACK stays 0; pending returns to 0.
- Masters 0 and 1 both raise CYC continuously, each doing 1 write per CYC then releasing -> grants alternate 0,1,0,1; a 2-cycle gap between grants; no master granted twice consecutively.
- MAX_PENDING=1, m0 streams 3 writes with slave ACK 1 cycle after accept -> m0 stall high while pending=1; exactly 3 slave accepts and 3 ACKs; o_s_dat/sel match each write.
- Slave returns ERR for adr 0xFC (unmapped) -> m0 ERR pulses for 1 cycle, ACK stays 0, pending=0.
- TIMEOUT_CYCLES=8, MAX_PENDING=2, slave never responds to 2 accepted requests -> ABORT 8 cycles after last accept; o_s_cyc=0; m0 receives 2 consecutive ERR pulses; then OWNED with pending=0.
- m0 drops CYC with pending=1, slave then sends a late ACK; also assert i_rst mid-transfer -> late ACK not forwarded to any master; m1 granted 2 cycles after release; after i_rst all outputs return to reset values immediately.
